// File: rtl/rvfi_mon_pkg.sv
// Shared types for the RVFI retirement monitor: error causes, monitor
// states and the compact trace entry carried by the trace FIFO.
package rvfi_mon_pkg;

  localparam int TRACE_XLEN = 32;

  typedef enum logic [3:0] {
    ERR_NONE      = 4'd0,
    ERR_ORDER     = 4'd1,
    ERR_PC        = 4'd2,
    ERR_X0        = 4'd3,
    ERR_RS1       = 4'd4,
    ERR_RS2       = 4'd5,
    ERR_POST_HALT = 4'd6
  } err_code_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           insn;
    logic [4:0]            rd_addr;
    logic [TRACE_XLEN-1:0] rd_wdata;
  } trace_entry_t;

endpackage

// File: rtl/rvfi_trace_fifo.sv
// Retirement trace FIFO, no fall-through. Pointers carry one extra wrap bit
// so full and empty are distinguishable. A push into a full FIFO is dropped
// and counted unless a pop frees a slot in the same cycle.
import rvfi_mon_pkg::*;

module rvfi_trace_fifo #(
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  trace_entry_t push_data,
  output logic         out_valid,
  input  logic         out_ready,
  output trace_entry_t head,
  output logic [15:0]  dropped
);

  localparam int AW = $clog2(DEPTH);

  trace_entry_t  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          drop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = out_ready && !empty;
  assign do_push   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign out_valid = !empty;
  // Head is forced to zero while empty so the idle outputs read as zero.
  assign head      = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer and drop-counter control; reset flushes the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      dropped <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
    end
  end

  // Entry storage; contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rvfi_monitor.sv
// Passive single-retire RVFI monitor. Checks order, PC continuity and x0
// writes on every retirement in RUN, latches the first violation, and pushes
// a compact trace of each checked retirement into rvfi_trace_fifo.
// Optional macro RVFI_MON_SHADOW_EN adds a shadow register file that checks
// rs1/rs2 read data (codes 4 and 5); without it those codes never occur.
import rvfi_mon_pkg::*;

module rvfi_monitor #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rvfi_valid,
  input  logic [63:0]     rvfi_order,
  input  logic [31:0]     rvfi_insn,
  input  logic            rvfi_trap,
  input  logic            rvfi_halt,
  input  logic [4:0]      rvfi_rs1_addr,
  input  logic [4:0]      rvfi_rs2_addr,
  input  logic [XLEN-1:0] rvfi_rs1_rdata,
  input  logic [XLEN-1:0] rvfi_rs2_rdata,
  input  logic [4:0]      rvfi_rd_addr,
  input  logic [XLEN-1:0] rvfi_rd_wdata,
  input  logic [XLEN-1:0] rvfi_pc_rdata,
  input  logic [XLEN-1:0] rvfi_pc_wdata,
  output logic            err_valid,
  output logic [3:0]      err_code,
  output logic [63:0]     err_order,
  output logic            halted,
  output logic [63:0]     retire_count,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [XLEN-1:0] trace_pc,
  output logic [31:0]     trace_insn,
  output logic [4:0]      trace_rd_addr,
  output logic [XLEN-1:0] trace_rd_wdata,
  output logic [15:0]     trace_dropped
);

  state_e          state_q;
  state_e          state_d;
  err_code_e       chk_code;
  err_code_e       fail_code;
  logic            err_set;
  logic            checked;
  logic            post_halt;
  logic            rs1_bad;
  logic            rs2_bad;
  logic [XLEN-1:0] prev_pc_q;
  trace_entry_t    push_entry;
  trace_entry_t    head;

  assign checked   = rvfi_valid && (state_q == ST_RUN);
  assign post_halt = rvfi_valid && (state_q == ST_HALT);

`ifdef RVFI_MON_SHADOW_EN
  logic [XLEN-1:0] shadow_mem [32];
  logic [31:0]     shadow_vld;
  logic            shadow_wr;

  assign shadow_wr = checked && !rvfi_trap && (rvfi_rd_addr != 5'd0);

  // Shadow valid bits: a register is only checked once it has been written.
  always_ff @(posedge clock) begin
    if (reset) shadow_vld <= '0;
    else if (shadow_wr) shadow_vld[rvfi_rd_addr] <= 1'b1;
  end

  // Shadow data, visible to the next retirement.
  always_ff @(posedge clock) begin
    if (shadow_wr) shadow_mem[rvfi_rd_addr] <= rvfi_rd_wdata;
  end

  assign rs1_bad = !rvfi_trap &&
                   ((rvfi_rs1_addr == 5'd0) ? (rvfi_rs1_rdata != '0) :
                    (shadow_vld[rvfi_rs1_addr] && shadow_mem[rvfi_rs1_addr] != rvfi_rs1_rdata));
  assign rs2_bad = !rvfi_trap &&
                   ((rvfi_rs2_addr == 5'd0) ? (rvfi_rs2_rdata != '0) :
                    (shadow_vld[rvfi_rs2_addr] && shadow_mem[rvfi_rs2_addr] != rvfi_rs2_rdata));
`else
  logic unused_shadow_inputs;
  assign unused_shadow_inputs = ^{rvfi_trap, rvfi_rs1_addr, rvfi_rs2_addr,
                                  rvfi_rs1_rdata, rvfi_rs2_rdata};
  assign rs1_bad = 1'b0;
  assign rs2_bad = 1'b0;
`endif

  // Invariant checks in priority order; the lowest code wins.
  always_comb begin
    chk_code = ERR_NONE;
    if (rvfi_order != retire_count)
      chk_code = ERR_ORDER;
    else if (retire_count != 64'd0 && rvfi_pc_rdata != prev_pc_q)
      chk_code = ERR_PC;
    else if (rvfi_rd_addr == 5'd0 && rvfi_rd_wdata != '0)
      chk_code = ERR_X0;
    else if (rs1_bad)
      chk_code = ERR_RS1;
    else if (rs2_bad)
      chk_code = ERR_RS2;
  end

  // Next state and first-violation capture.
  always_comb begin
    state_d   = state_q;
    err_set   = 1'b0;
    fail_code = chk_code;
    case (state_q)
      ST_RUN: begin
        if (checked) begin
          if (chk_code != ERR_NONE) begin
            state_d = ST_FAIL;
            err_set = 1'b1;
          end else if (rvfi_halt) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (post_halt) begin
          state_d   = ST_FAIL;
          err_set   = 1'b1;
          fail_code = ERR_POST_HALT;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Control state and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      err_valid    <= 1'b0;
      err_code     <= 4'd0;
      err_order    <= 64'd0;
      halted       <= 1'b0;
      retire_count <= 64'd0;
    end else begin
      state_q <= state_d;
      if (err_set) begin
        err_valid <= 1'b1;
        err_code  <= fail_code;
        err_order <= rvfi_order;
      end
      if (checked) retire_count <= retire_count + 64'd1;
      if (checked && rvfi_halt) halted <= 1'b1;
    end
  end

  // Previous next-PC; only consulted once at least one retirement is counted.
  always_ff @(posedge clock) begin
    if (checked) prev_pc_q <= rvfi_pc_wdata;
  end

  assign push_entry.pc       = rvfi_pc_rdata;
  assign push_entry.insn     = rvfi_insn;
  assign push_entry.rd_addr  = rvfi_rd_addr;
  assign push_entry.rd_wdata = rvfi_rd_wdata;

  rvfi_trace_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (checked),
    .push_data (push_entry),
    .out_valid (trace_valid),
    .out_ready (trace_ready),
    .head      (head),
    .dropped   (trace_dropped)
  );

  assign trace_pc       = head.pc;
  assign trace_insn     = head.insn;
  assign trace_rd_addr  = head.rd_addr;
  assign trace_rd_wdata = head.rd_wdata;

endmodule

// File: tb/tb_rvfi_monitor.sv
// Self-checking bench for rvfi_monitor: directed scenarios followed by
// randomized retirement streams, all compared against a queue-based model.
module tb_rvfi_monitor;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
`ifdef RVFI_MON_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            rvfi_valid;
  logic [63:0]     rvfi_order;
  logic [31:0]     rvfi_insn;
  logic            rvfi_trap;
  logic            rvfi_halt;
  logic [4:0]      rvfi_rs1_addr;
  logic [4:0]      rvfi_rs2_addr;
  logic [XLEN-1:0] rvfi_rs1_rdata;
  logic [XLEN-1:0] rvfi_rs2_rdata;
  logic [4:0]      rvfi_rd_addr;
  logic [XLEN-1:0] rvfi_rd_wdata;
  logic [XLEN-1:0] rvfi_pc_rdata;
  logic [XLEN-1:0] rvfi_pc_wdata;
  logic            err_valid;
  logic [3:0]      err_code;
  logic [63:0]     err_order;
  logic            halted;
  logic [63:0]     retire_count;
  logic            trace_valid;
  logic            trace_ready;
  logic [XLEN-1:0] trace_pc;
  logic [31:0]     trace_insn;
  logic [4:0]      trace_rd_addr;
  logic [XLEN-1:0] trace_rd_wdata;
  logic [15:0]     trace_dropped;

  always #5 clock = ~clock;

  rvfi_monitor #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
    .rvfi_halt(rvfi_halt), .rvfi_rs1_addr(rvfi_rs1_addr),
    .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
    .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata), .err_valid(err_valid), .err_code(err_code),
    .err_order(err_order), .halted(halted), .retire_count(retire_count),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
    .trace_insn(trace_insn), .trace_rd_addr(trace_rd_addr),
    .trace_rd_wdata(trace_rd_wdata), .trace_dropped(trace_dropped)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  ent_t        m_q[$];
  int          m_state;      // 0 running, 1 halted, 2 failed
  logic [63:0] m_count;
  logic [31:0] m_prev_pc;
  logic [31:0] m_shadow [32];
  bit          m_shv [32];
  logic [15:0] m_dropped;
  bit          m_err_valid;
  logic [3:0]  m_err_code;
  logic [63:0] m_err_order;
  bit          m_halted;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state     = 0;
    m_count     = 64'd0;
    m_prev_pc   = 32'd0;
    m_dropped   = 16'd0;
    m_err_valid = 1'b0;
    m_err_code  = 4'd0;
    m_err_order = 64'd0;
    m_halted    = 1'b0;
    for (int i = 0; i < 32; i++) m_shv[i] = 1'b0;
  endtask

  function automatic bit rs_ok(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return d == 32'd0;
    return !m_shv[a] || (m_shadow[a] == d);
  endfunction

  task automatic model_step();
    int   code;
    int   sz;
    bit   pop;
    ent_t e;
    if (reset) begin
      model_reset();
      return;
    end
    sz  = m_q.size();
    pop = trace_ready && (sz > 0);
    if (pop) m_q.delete(0);
    if (rvfi_valid && m_state == 0) begin
      code = 0;
      if (rvfi_order != m_count) code = 1;
      else if (m_count != 0 && rvfi_pc_rdata != m_prev_pc) code = 2;
      else if (rvfi_rd_addr == 5'd0 && rvfi_rd_wdata != 32'd0) code = 3;
      else if (SHADOW && !rvfi_trap && !rs_ok(rvfi_rs1_addr, rvfi_rs1_rdata)) code = 4;
      else if (SHADOW && !rvfi_trap && !rs_ok(rvfi_rs2_addr, rvfi_rs2_rdata)) code = 5;
      m_count   = m_count + 64'd1;
      m_prev_pc = rvfi_pc_wdata;
      e.pc = rvfi_pc_rdata; e.insn = rvfi_insn; e.rd = rvfi_rd_addr; e.wd = rvfi_rd_wdata;
      if (sz < DEPTH || pop) m_q.push_back(e);
      else if (m_dropped != 16'hFFFF) m_dropped = m_dropped + 16'd1;
      if (SHADOW && !rvfi_trap && rvfi_rd_addr != 5'd0) begin
        m_shadow[rvfi_rd_addr] = rvfi_rd_wdata;
        m_shv[rvfi_rd_addr]    = 1'b1;
      end
      if (rvfi_halt) m_halted = 1'b1;
      if (code != 0) begin
        m_state = 2; m_err_valid = 1'b1; m_err_code = 4'(code); m_err_order = rvfi_order;
      end else if (rvfi_halt) begin
        m_state = 1;
      end
    end else if (rvfi_valid && m_state == 1) begin
      m_state = 2; m_err_valid = 1'b1; m_err_code = 4'd6; m_err_order = rvfi_order;
    end
  endtask

  task automatic check_all();
    chk("err_valid", 64'(err_valid), 64'(m_err_valid));
    chk("err_code", 64'(err_code), 64'(m_err_code));
    chk("err_order", err_order, m_err_order);
    chk("halted", 64'(halted), 64'(m_halted));
    chk("retire_count", retire_count, m_count);
    chk("trace_valid", 64'(trace_valid), 64'(m_q.size() > 0));
    chk("trace_dropped", 64'(trace_dropped), 64'(m_dropped));
    if (m_q.size() > 0) begin
      chk("trace_pc", 64'(trace_pc), 64'(m_q[0].pc));
      chk("trace_insn", 64'(trace_insn), 64'(m_q[0].insn));
      chk("trace_rd_addr", 64'(trace_rd_addr), 64'(m_q[0].rd));
      chk("trace_rd_wdata", 64'(trace_rd_wdata), 64'(m_q[0].wd));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clock);
    #1;
    model_step();
    check_all();
  endtask

  task automatic idle();
    rvfi_valid = 1'b0;
  endtask

  task automatic set_legal(input logic [4:0] rd, input logic [31:0] wd);
    rvfi_valid     = 1'b1;
    rvfi_order     = m_count;
    rvfi_pc_rdata  = (m_count == 0) ? 32'h1000 : m_prev_pc;
    rvfi_pc_wdata  = rvfi_pc_rdata + 32'd4;
    rvfi_insn      = $urandom;
    rvfi_rd_addr   = rd;
    rvfi_rd_wdata  = (rd == 5'd0) ? 32'd0 : wd;
    rvfi_rs1_addr  = 5'd0;
    rvfi_rs2_addr  = 5'd0;
    rvfi_rs1_rdata = 32'd0;
    rvfi_rs2_rdata = 32'd0;
    rvfi_trap      = 1'b0;
    rvfi_halt      = 1'b0;
  endtask

  task automatic do_reset(input bit with_valid);
    reset      = 1'b1;
    rvfi_valid = with_valid;
    cycle();
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    chk("rst_count", retire_count, 64'd0);
    chk("rst_trace_valid", 64'(trace_valid), 64'd0);
    chk("rst_trace_pc", 64'(trace_pc), 64'd0);
    chk("rst_trace_wdata", 64'(trace_rd_wdata), 64'd0);
    reset      = 1'b0;
    rvfi_valid = 1'b0;
  endtask

  function automatic logic [31:0] rs_val(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    return m_shv[a] ? m_shadow[a] : $urandom;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    trace_ready = 1'b0;
    set_legal(5'd0, 32'd0);
    rvfi_valid = 1'b0;
    model_reset();
    do_reset(1'b0);

    // Five clean retirements, then drain.
    for (int i = 0; i < 5; i++) begin
      set_legal(5'(i + 1), 32'h100 + 32'(i));
      cycle();
    end
    idle();
    trace_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("s1_count", retire_count, 64'd5);
    chk("s1_err", 64'(err_valid), 64'd0);

    // Order violation on the third retirement.
    do_reset(1'b0);
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_legal(5'd1, 32'(i));
      if (i == 2) rvfi_order = 64'd7;
      cycle();
    end
    chk("s2_code", 64'(err_code), 64'd1);
    chk("s2_order", err_order, 64'd7);
    idle();

    // x0 write with and without a simultaneous order error.
    do_reset(1'b0);
    set_legal(5'd0, 32'd0);
    rvfi_rd_wdata = 32'h5;
    rvfi_order    = 64'd1;
    cycle();
    chk("s3_prio", 64'(err_code), 64'd1);
    do_reset(1'b0);
    set_legal(5'd0, 32'd0);
    rvfi_rd_wdata = 32'h5;
    cycle();
    chk("s3_x0", 64'(err_code), 64'd3);

    // Shadow register mismatch.
    do_reset(1'b0);
    set_legal(5'd3, 32'hDEAD);
    cycle();
    set_legal(5'd4, 32'd1);
    rvfi_rs1_addr  = 5'd3;
    rvfi_rs1_rdata = 32'hBEEF;
    cycle();
    chk("s4_shadow", 64'(err_code), SHADOW ? 64'd4 : 64'd0);

    // Overfill, then push and pop while full.
    do_reset(1'b0);
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      set_legal(5'd2, 32'(i));
      cycle();
    end
    chk("s5_dropped", 64'(trace_dropped), 64'd3);
    trace_ready = 1'b1;
    set_legal(5'd2, 32'h77);
    cycle();
    chk("s5_pushpop", 64'(trace_dropped), 64'd3);
    idle();
    trace_ready = 1'b0;

    // Halt, then a post-halt retirement, then reset mid-stream.
    do_reset(1'b0);
    set_legal(5'd1, 32'h1);
    rvfi_halt = 1'b1;
    cycle();
    chk("s6_halted", 64'(halted), 64'd1);
    set_legal(5'd1, 32'h2);
    cycle();
    chk("s6_code", 64'(err_code), 64'd6);
    set_legal(5'd1, 32'h3);
    do_reset(1'b1);
    chk("s6_rst_code", 64'(err_code), 64'd0);
    chk("s6_rst_halted", 64'(halted), 64'd0);

    // Randomized streams with occasional faults.
    for (int r = 0; r < 4; r++) begin
      do_reset(1'b0);
      for (int n = 0; n < 300; n++) begin
        int sel;
        trace_ready = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 99);
        if (sel < 10) begin
          idle();
        end else begin
          set_legal(5'($urandom_range(0, 31)), $urandom);
          rvfi_rs1_addr  = 5'($urandom_range(0, 31));
          rvfi_rs2_addr  = 5'($urandom_range(0, 31));
          rvfi_rs1_rdata = rs_val(rvfi_rs1_addr);
          rvfi_rs2_rdata = rs_val(rvfi_rs2_addr);
          if (sel >= 95) begin
            case ($urandom_range(0, 6))
              0: rvfi_order     = rvfi_order + 64'd1;
              1: rvfi_pc_rdata  = rvfi_pc_rdata ^ 32'h10;
              2: begin rvfi_rd_addr = 5'd0; rvfi_rd_wdata = 32'h1 | $urandom; end
              3: rvfi_rs1_rdata = rvfi_rs1_rdata ^ 32'h1;
              4: rvfi_rs2_rdata = rvfi_rs2_rdata ^ 32'h2;
              5: begin rvfi_trap = 1'b1; rvfi_rs1_rdata = rvfi_rs1_rdata ^ 32'h4; end
              default: rvfi_halt = 1'b1;
            endcase
          end
        end
        cycle();
      end
      idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
